// File: rtl/vec_irq_ctrl.sv
// Vectored interrupt controller: N prioritised edge/level lines, per-line mask,
// nesting stack of in-service levels and per-line vector generation for the CU.
module vec_irq_ctrl #(
  parameter int          N_IRQ      = 8,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0010,
  parameter logic [31:0] VEC_STRIDE = 32'd1,
  localparam int         ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
  localparam int         D_W        = $clog2(NEST_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] edge_mode,
  input  logic             mask_wr,
  input  logic [N_IRQ-1:0] mask_in,
  output logic [N_IRQ-1:0] mask,
  output logic             irq_out,
  output logic [ID_W-1:0]  irq_id,
  input  logic             ack,
  input  logic             eoi,
  output logic [31:0]      vector,
  output logic [D_W-1:0]   depth,
  output logic             nest_full,
  output logic             spurious
);

  localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam int CUR_W = $clog2(N_IRQ + 1);

  logic [N_IRQ-1:0] s1_reg, s2_reg, s3_reg;
  logic [N_IRQ-1:0] pending_reg, pending_next;
  logic [N_IRQ-1:0] mask_reg;
  logic [ID_W-1:0]  stack_reg [NEST_DEPTH];
  logic [D_W-1:0]   depth_reg, depth_pop, depth_next;
  logic             irq_out_reg, spurious_reg;
  logic [ID_W-1:0]  irq_id_reg;
  logic [31:0]      vector_reg;

  logic             accept;
  logic [CUR_W-1:0] cur_next;
  logic             cand_valid;
  logic [ID_W-1:0]  cand_id;

  assign accept = ack & irq_out_reg;

  // A fresh rising edge beats the acknowledge clear of the same line.
  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
      logic rise;
      logic clr;
      assign rise = s2_reg[gi] & ~s3_reg[gi];
      assign clr  = accept && (irq_id_reg == ID_W'(gi));
      assign pending_next[gi] = edge_mode[gi] ? ((pending_reg[gi] & ~clr) | rise)
                                              : s2_reg[gi];
    end
  endgenerate

  // Stack is popped before the push so that ack+eoi replaces the top entry.
  // The candidate is judged against the post-update level so irq_out drops right after ack.
  always_comb begin
    depth_pop  = depth_reg;
    cur_next   = CUR_W'(N_IRQ);
    cand_valid = 1'b0;
    cand_id    = '0;
    if (eoi && depth_reg != '0)
      depth_pop = depth_reg - D_W'(1);
    depth_next = accept ? depth_pop + D_W'(1) : depth_pop;
    if (accept)
      cur_next = CUR_W'(irq_id_reg);
    else if (depth_pop != '0)
      cur_next = CUR_W'(stack_reg[IDX_W'(depth_pop - D_W'(1))]);
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending_reg[i] && mask_reg[i] && (CUR_W'(i) < cur_next)) begin
        cand_valid = 1'b1;
        cand_id    = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg       <= '0;
      s2_reg       <= '0;
      s3_reg       <= '0;
      pending_reg  <= '0;
      mask_reg     <= '0;
      depth_reg    <= '0;
      irq_out_reg  <= 1'b0;
      irq_id_reg   <= '0;
      vector_reg   <= VEC_BASE;
      spurious_reg <= 1'b0;
      for (int j = 0; j < NEST_DEPTH; j++)
        stack_reg[j] <= '0;
    end else begin
      s1_reg      <= irq_in;
      s2_reg      <= s1_reg;
      s3_reg      <= s2_reg;
      pending_reg <= pending_next;
      if (mask_wr)
        mask_reg <= mask_in;
      depth_reg <= depth_next;
      if (accept) begin
        stack_reg[IDX_W'(depth_pop)] <= irq_id_reg;
        vector_reg <= VEC_BASE + 32'(irq_id_reg) * VEC_STRIDE;
      end
      irq_out_reg  <= cand_valid && (depth_next != D_W'(NEST_DEPTH));
      irq_id_reg   <= cand_id;
      spurious_reg <= (ack & ~irq_out_reg) | (eoi && depth_reg == '0);
    end
  end

  assign mask      = mask_reg;
  assign irq_out   = irq_out_reg;
  assign irq_id    = irq_id_reg;
  assign vector    = vector_reg;
  assign depth     = depth_reg;
  assign nest_full = (depth_reg == D_W'(NEST_DEPTH));
  assign spurious  = spurious_reg;

endmodule
